clk_gen_ctrl: RTL

CLK_GEN_CTRL -- requirements
Module: clk_gen_ctrl

---
 rtl/clk_gen_ctrl_pkg.sv | 12 +
 rtl/clk_gen_ctrl_half_period_counter.sv | 43 ++++
 rtl/clk_gen_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/clk_gen_ctrl_pkg.sv
// Shared types and constants for the programmable clock generator.
package clk_gen_ctrl_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StLow  = 2'd2
    } gen_state_e;

endpackage

// File: rtl/clk_gen_ctrl_half_period_counter.sv
// Loadable down-counter timing one half-period of the generated clock.
module half_period_counter
    import clk_gen_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Saturates at zero so an idle block holds its count.
    always_comb begin
        cnt_d = cnt_q;
        if (clk_en) begin
            if (load_en) begin
                cnt_d = load_val;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clk_gen_ctrl.sv
// Generates a clock with programmable high/low half-periods counted in enabled ticks,
// with start, period-aligned stop and registered edge strobes.
module clk_gen_ctrl
    import clk_gen_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic [CNT_W-1:0] cfg_high_i,
    input  logic [CNT_W-1:0] cfg_low_i,
    input  logic             start_i,
    input  logic             stop_i,
    output logic             gen_clk_o,
    output logic             busy_o,
    output logic             rise_o,
    output logic             fall_o
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    gen_state_e       state_d, state_q;
    logic             gen_clk_d, gen_clk_q;
    logic             rise_d, rise_q;
    logic             fall_d, fall_q;
    logic             stop_pending_d, stop_pending_q;
    logic [CNT_W-1:0] cfg_high_d, cfg_high_q;
    logic [CNT_W-1:0] cfg_low_d, cfg_low_q;

    logic             load_en;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    // Reload value for a phase: a zero config behaves as a one-tick phase.
    function automatic logic [CNT_W-1:0] phase_reload(input logic [CNT_W-1:0] cfg);
        return (cfg == '0) ? '0 : cfg - CntOne;
    endfunction

    half_period_counter #(
        .CNT_W (CNT_W)
    ) u_half_period_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .load_en  (load_en),
        .load_val (load_val),
        .cnt_o    (cnt),
        .zero_o   (cnt_zero)
    );

    always_comb begin
        state_d        = state_q;
        gen_clk_d      = gen_clk_q;
        rise_d         = 1'b0;
        fall_d         = 1'b0;
        cfg_high_d     = cfg_high_q;
        cfg_low_d      = cfg_low_q;
        load_en        = 1'b0;
        load_val       = '0;
        // Stop requests are captured on every clk, not just enabled ticks.
        stop_pending_d = stop_pending_q | (stop_i & (state_q != StIdle));

        if (clk_en) begin
            unique case (state_q)
                StIdle: begin
                    if (start_i && !stop_i) begin
                        state_d    = StHigh;
                        gen_clk_d  = 1'b1;
                        rise_d     = 1'b1;
                        cfg_high_d = cfg_high_i;
                        cfg_low_d  = cfg_low_i;
                        load_en    = 1'b1;
                        load_val   = phase_reload(cfg_high_i);
                    end
                end
                StHigh: begin
                    if (cnt_zero) begin
                        state_d   = StLow;
                        gen_clk_d = 1'b0;
                        fall_d    = 1'b1;
                        load_en   = 1'b1;
                        load_val  = phase_reload(cfg_low_q);
                    end
                end
                StLow: begin
                    if (cnt_zero) begin
                        if (stop_pending_q) begin
                            state_d        = StIdle;
                            stop_pending_d = 1'b0;
                        end else begin
                            state_d    = StHigh;
                            gen_clk_d  = 1'b1;
                            rise_d     = 1'b1;
                            cfg_high_d = cfg_high_i;
                            cfg_low_d  = cfg_low_i;
                            load_en    = 1'b1;
                            load_val   = phase_reload(cfg_high_i);
                        end
                    end
                end
                default: begin
                    state_d   = StIdle;
                    gen_clk_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            gen_clk_q      <= 1'b0;
            rise_q         <= 1'b0;
            fall_q         <= 1'b0;
            stop_pending_q <= 1'b0;
            cfg_high_q     <= '0;
            cfg_low_q      <= '0;
        end else begin
            state_q        <= state_d;
            gen_clk_q      <= gen_clk_d;
            rise_q         <= rise_d;
            fall_q         <= fall_d;
            stop_pending_q <= stop_pending_d;
            cfg_high_q     <= cfg_high_d;
            cfg_low_q      <= cfg_low_d;
        end
    end

    assign gen_clk_o = gen_clk_q;
    assign busy_o    = (state_q != StIdle);
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;

endmodule
